// File: rtl/ballot_unit.sv
// Ballot controller: conditions three candidate buttons (sync, debounce, edge
// detect) and issues at most one single-cycle vote pulse per officer authorisation.
module ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       voter_en,
    input  logic       btn_C1,
    input  logic       btn_C2,
    input  logic       btn_C3,
    output logic       vote_C1,
    output logic       vote_C2,
    output logic       vote_C3,
    output logic       ready,
    output logic       busy,
    output logic       invalid,
    output logic [7:0] ballots_cast
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        CAST    = 3'd2,
        REJECT  = 3'd3,
        RELEASE = 3'd4,
        LOCKOUT = 3'd5
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        popcount3 = {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            deb_q, deb_d, deb_prev_q;
    logic [2:0][DB_W-1:0]  cnt_q, cnt_d;
    logic [2:0]            press_s;

    state_t                state_q, state_d;
    logic [LK_W-1:0]       lock_q, lock_d;
    logic [2:0]            vote_q, vote_d;
    logic                  invalid_q, invalid_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic [7:0]            count_q, count_d;

    assign press_s = deb_q & ~deb_prev_q;

    // Debounce: flip the level after DEBOUNCE_CYCLES consecutive differing samples
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Button front end registers: synchroniser, debounced level, edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            deb_q      <= 3'b000;
            deb_prev_q <= 3'b000;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= {btn_C3, btn_C2, btn_C1};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // Ballot FSM next state; vote/invalid are decided on the transition so they register cleanly
    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        vote_d    = 3'b000;
        invalid_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            IDLE: begin
                if (voter_en) begin
                    state_d = ARMED;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (press_s != 3'b000) begin
                    if (popcount3(deb_q) >= 2'd2) begin
                        state_d   = REJECT;
                        invalid_d = 1'b1;
                    end else begin
                        state_d = CAST;
                        vote_d  = press_s;
                        if (count_q != 8'd255) begin
                            count_d = count_q + 8'd1;
                        end else begin
                            count_d = count_q;
                        end
                    end
                end else begin
                    state_d = ARMED;
                end
            end
            CAST: begin
                state_d = RELEASE;
            end
            REJECT: begin
                if (deb_q == 3'b000) begin
                    state_d = ARMED;
                end else begin
                    state_d = REJECT;
                end
            end
            RELEASE: begin
                if (deb_q == 3'b000) begin
                    state_d = LOCKOUT;
                    lock_d  = '0;
                end else begin
                    state_d = RELEASE;
                end
            end
            LOCKOUT: begin
                if (lock_q == LK_LAST) begin
                    state_d = IDLE;
                end else begin
                    lock_d = lock_q + LK_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == ARMED);
        busy_d  = (state_d != IDLE);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_q    <= '0;
            vote_q    <= 3'b000;
            invalid_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            vote_q    <= vote_d;
            invalid_q <= invalid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    assign vote_C1      = vote_q[0];
    assign vote_C2      = vote_q[1];
    assign vote_C3      = vote_q[2];
    assign invalid      = invalid_q;
    assign ready        = ready_q;
    assign busy         = busy_q;
    assign ballots_cast = count_q;

endmodule

// File: tb/tb_ballot_unit.sv
// Scoreboard bench for ballot_unit: stimulus pushes expected vote/invalid pulses
// with their cycle; a negedge monitor pops and compares whenever a pulse appears.
module tb_ballot_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       voter_en;
    logic       btn_C1, btn_C2, btn_C3;
    logic       vote_C1, vote_C2, vote_C3;
    logic       ready, busy, invalid;
    logic [7:0] ballots_cast;

    typedef struct {
        logic [2:0] vote;
        logic       inv;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   exp_count = 0;

    ballot_unit dut (
        .clk(clk), .rst(rst), .voter_en(voter_en),
        .btn_C1(btn_C1), .btn_C2(btn_C2), .btn_C3(btn_C3),
        .vote_C1(vote_C1), .vote_C2(vote_C2), .vote_C3(vote_C3),
        .ready(ready), .busy(busy), .invalid(invalid),
        .ballots_cast(ballots_cast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard, on time
    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            tests_run++;
            tests_failed++;
            $display("FAIL missed_pulse: expected vote=%b inv=%b at cycle %0d, no pulse observed",
                     mon_e.vote, mon_e.inv, mon_e.cyc);
        end
        if ({vote_C3, vote_C2, vote_C1} != 3'b000 || invalid) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_pulse at cycle %0d: vote=%b inv=%b, expected none",
                         cyc, {vote_C3, vote_C2, vote_C1}, invalid);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.vote != {vote_C3, vote_C2, vote_C1} || mon_e.inv != invalid
                    || mon_e.cyc != cyc) begin
                    tests_failed++;
                    $display("FAIL pulse: got vote=%b inv=%b cycle %0d, expected vote=%b inv=%b cycle %0d",
                             {vote_C3, vote_C2, vote_C1}, invalid, cyc,
                             mon_e.vote, mon_e.inv, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_btn(input logic [2:0] b);
        {btn_C3, btn_C2, btn_C1} = b;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, int'({vote_C3, vote_C2, vote_C1, ready, busy, invalid}), 0);
        check({name, "_count"}, int'(ballots_cast), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        check_all_zero("reset");
    endtask

    task automatic arm();
        voter_en = 1'b1;
        @(negedge clk);
        voter_en = 1'b0;
        check("arm_ready", int'(ready), 1);
    endtask

    // Clean press of b for 10 cycles while ARMED; waits until back in IDLE
    task automatic cast(input logic [2:0] b);
        int c0;
        c0 = cyc;
        set_btn(b);
        sb_q.push_back('{vote: b, inv: 1'b0, cyc: c0 + 7});
        exp_count = (exp_count == 255) ? 255 : exp_count + 1;
        wait_cyc(c0 + 10);
        set_btn(3'b000);
        wait_cyc(c0 + 24);
        check("busy_last_lockout", int'(busy), 1);
        wait_cyc(c0 + 25);
        check("busy_dropped", int'(busy), 0);
        check("ballots_cast", int'(ballots_cast), exp_count);
    endtask

    initial begin
        int c;
        rst = 1'b1;
        voter_en = 1'b0;
        set_btn(3'b000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("initial_reset");

        // Basic cast on C2
        arm();
        cast(3'b010);

        // Press while unarmed, then a short glitch while armed
        c = cyc;
        set_btn(3'b001);
        wait_cyc(c + 10);
        set_btn(3'b000);
        wait_cyc(c + 25);
        check("unarmed_ready", int'(ready), 0);
        check("unarmed_busy", int'(busy), 0);
        check("unarmed_count", int'(ballots_cast), 1);
        arm();
        c = cyc;
        set_btn(3'b100);
        wait_cyc(c + 2);
        set_btn(3'b000);
        wait_cyc(c + 15);
        check("glitch_ready", int'(ready), 1);

        // Multi-press reject, then clean C3 ballot
        do_reset();
        arm();
        c = cyc;
        set_btn(3'b101);
        sb_q.push_back('{vote: 3'b000, inv: 1'b1, cyc: c + 7});
        wait_cyc(c + 8);
        check("reject_ready", int'(ready), 0);
        check("reject_busy", int'(busy), 1);
        wait_cyc(c + 10);
        set_btn(3'b000);
        wait_cyc(c + 20);
        check("rearmed_ready", int'(ready), 1);
        cast(3'b100);

        // Held across voter_en, release, press, then a second press during lockout
        c = cyc;
        set_btn(3'b001);
        wait_cyc(c + 10);
        arm();
        set_btn(3'b000);
        wait_cyc(c + 21);
        c = cyc;
        set_btn(3'b001);
        sb_q.push_back('{vote: 3'b001, inv: 1'b0, cyc: c + 7});
        exp_count++;
        wait_cyc(c + 10);
        set_btn(3'b000);
        wait_cyc(c + 18);
        voter_en = 1'b1;
        @(negedge clk);
        voter_en = 1'b0;
        wait_cyc(c + 20);
        set_btn(3'b001);
        wait_cyc(c + 30);
        set_btn(3'b000);
        check("no_queued_en_ready", int'(ready), 0);
        check("no_queued_en_busy", int'(busy), 0);
        wait_cyc(c + 45);
        check("double_vote_count", int'(ballots_cast), exp_count);

        // Reset one cycle before the debounced level would rise
        do_reset();
        arm();
        c = cyc;
        set_btn(3'b010);
        wait_cyc(c + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_btn(3'b000);
        check_all_zero("mid_reset");
        wait_cyc(c + 30);
        check("after_reset_ready", int'(ready), 0);
        check("after_reset_count", int'(ballots_cast), 0);

        // 256 ballots: count saturates at 255, pulses continue
        for (int i = 0; i < 256; i++) begin
            arm();
            cast(3'b001 << (i % 3));
        end
        check("saturated_count", int'(ballots_cast), 255);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
